hstx_lane_ctrl: RTL and testbench
=================================

HSTX_LANE_CTRL -- requirements
Module: hstx_lane_ctrl

Interface
REQ-001 Parameters (name, default, meaning), all counts in TxByteClkHS cycles, 8-bit, value 0 treated as 1:
- T_LPX, 4, duration of LP-01 and of LP-00
- T_HS_PREPARE, 3, HS-0 prepare time
- T_HS_ZERO, 10, HS-0 zero time
- T_HS_TRAIL, 4, trail time
- T_HS_EXIT, 5, LP-11 exit time
REQ-002 Ports (name, direction, width, meaning):
- TxByteClkHS, in, 1, single clock; all logic on its rising edge
- TxRst, in, 1, synchronous active-low reset
- TxRequestHS, in, 1, PPI HS transmit request
- TxDataHS, in, 8, PPI payload byte
- TxReadyHS, out, 1, PPI byte accepted strobe
- hstx_ready, in, 1, HS-TX core reports HS_DATA state
- hstx_sot, out, 1, start-of-transmission pulse to HS-TX core
- hstx_valid, out, 1, byte valid to HS-TX core
- hstx_byte, out, 8, byte to HS-TX core
- hs_en, out, 1, HS driver enable
- lp_dp, out, 1, LP driver Dp level
- lp_dn, out, 1, LP driver Dn level
- ctrl_state, out, 4, current state encoding

Function
REQ-003 The block SHALL implement states LP_IDLE=0, LP_RQST=1, LP_BRIDGE=2, HS_PREP=3, HS_ZERO=4, HS_SYNC=5, HS_DATA=6, HS_TRAIL=7, HS_EXIT=8, exposed on ctrl_state.
REQ-004 LP_IDLE, HS_EXIT: lp_dp=1, lp_dn=1, hs_en=0; LP_RQST: lp_dp=0, lp_dn=1, hs_en=0; LP_BRIDGE: lp=00, hs_en=0; HS_PREP through HS_TRAIL: lp=00, hs_en=1.
REQ-005 A single 8-bit down-counter SHALL load T-1 on entry to each timed state and the state SHALL exit on the cycle the counter equals 0, giving exactly T cycles of residency.
REQ-006 Transitions: LP_IDLE->LP_RQST when TxRequestHS=1; LP_RQST->LP_BRIDGE after T_LPX; LP_BRIDGE->HS_PREP after T_LPX; HS_PREP->HS_ZERO after T_HS_PREPARE; HS_ZERO->HS_SYNC after T_HS_ZERO; HS_SYNC->HS_DATA when hstx_ready=1; HS_DATA->HS_TRAIL when TxRequestHS=0; HS_TRAIL->HS_EXIT after T_HS_TRAIL; HS_EXIT->LP_IDLE after T_HS_EXIT.
REQ-007 hstx_sot SHALL be 1 for exactly the first cycle of HS_SYNC; HS_SYNC waits indefinitely for hstx_ready.
REQ-008 In HS_DATA, TxReadyHS = hstx_ready AND TxRequestHS; a byte is transferred in every cycle both are 1, with hstx_byte=TxDataHS and hstx_valid=1 in the same cycle (zero latency, combinational pass-through).
REQ-009 The block SHALL register the last transferred byte's bit 7; in HS_TRAIL hstx_valid=1 and hstx_byte=8'hFF if that bit was 0, else 8'h00.
REQ-010 hstx_valid=0, hstx_byte=8'h00, TxReadyHS=0 in every state other than HS_DATA and HS_TRAIL.
REQ-011 TxRequestHS falling in LP_RQST..HS_ZERO SHALL not abort; the sequence proceeds through HS_SYNC, enters HS_DATA for one cycle with no transfer, then HS_TRAIL (last-bit register reset value 0 gives trail byte 8'hFF).
REQ-012 TxRequestHS re-asserted during HS_TRAIL or HS_EXIT SHALL be ignored until LP_IDLE is reached.

Reset
REQ-013 While TxRst=0 at a clock edge: state=LP_IDLE, counter=0, last-bit register=0, lp_dp=1, lp_dn=1, hs_en=0, hstx_sot=0, hstx_valid=0, hstx_byte=8'h00, TxReadyHS=0, ctrl_state=0.
REQ-014 Reset asserted in any state, including mid-burst, SHALL take effect on the next edge with no trail sequence.

Configuration
REQ-015 With HSTX_TIMING_PROG_EN defined, five 8-bit input ports cfg_t_lpx, cfg_t_hs_prepare, cfg_t_hs_zero, cfg_t_hs_trail, cfg_t_hs_exit SHALL replace the parameters, sampled into registers on the LP_IDLE->LP_RQST transition and held for the whole burst; without it those ports do not exist and the parameters apply.

Structure
REQ-016 State encoding constants and default timing values SHALL reside in the shared package dphy_hstx_pkg.
REQ-017 The timer SHALL be a sub-module hstx_ctrl_timer (load, value, done); all other logic in hstx_lane_ctrl.

Verification
REQ-018 Defaults, TxRequestHS=1 at cycle 0, hstx_ready=1 from HS_SYNC -> LP-01 cycles 1-4, LP-00 5-8, HS_PREP 9-11, HS_ZERO 12-21, hstx_sot=1 at cycle 22.
REQ-019 Burst of 3 bytes 8'hA5, 8'h3C, 8'h81, then TxRequestHS=0 -> three TxReadyHS pulses with matching hstx_byte, then 4 cycles of hstx_byte=8'h00, 5 cycles LP-11, ctrl_state=0.
REQ-020 Last byte 8'h7E -> trail byte 8'hFF for 4 cycles.
REQ-021 hstx_ready=0 toggling every other cycle in HS_DATA -> TxReadyHS only in ready cycles, no byte lost or duplicated.
REQ-022 TxRst=0 in HS_DATA mid-burst -> next edge lp=11, hs_en=0, hstx_valid=0, ctrl_state=0.
REQ-023 TxRequestHS dropped in HS_ZERO -> one HS_DATA cycle with no transfer, trail byte 8'hFF, return to LP_IDLE.

Source files
------------

// File: rtl/dphy_hstx_pkg.sv
// Shared definitions for the D-PHY HS transmit lane controller:
// state encoding, default timing values and the timer load helper.
package dphy_hstx_pkg;

  typedef enum logic [3:0] {
    LP_IDLE   = 4'd0,
    LP_RQST   = 4'd1,
    LP_BRIDGE = 4'd2,
    HS_PREP   = 4'd3,
    HS_ZERO   = 4'd4,
    HS_SYNC   = 4'd5,
    HS_DATA   = 4'd6,
    HS_TRAIL  = 4'd7,
    HS_EXIT   = 4'd8
  } ctrl_state_t;

  // Default state durations, in TxByteClkHS cycles.
  localparam logic [7:0] DEF_T_LPX        = 8'd4;
  localparam logic [7:0] DEF_T_HS_PREPARE = 8'd3;
  localparam logic [7:0] DEF_T_HS_ZERO    = 8'd10;
  localparam logic [7:0] DEF_T_HS_TRAIL   = 8'd4;
  localparam logic [7:0] DEF_T_HS_EXIT    = 8'd5;

  // Counter value to load on entry so the state lasts t cycles.
  // A duration of 0 is treated as 1 cycle.
  function automatic logic [7:0] timer_load_val(input logic [7:0] t);
    return (t == 8'd0) ? 8'd0 : t - 8'd1;
  endfunction

endpackage

// File: rtl/hstx_ctrl_timer.sv
// Single 8-bit down-counter for the lane controller's timed states.
// load has priority; otherwise the counter decrements until it reaches 0
// and holds there. done is high while the count is 0.
module hstx_ctrl_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] value,
  output logic       done
);

  logic [7:0] cnt;

  // Count register: synchronous active-low reset, load, or decrement to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign done = (cnt == 8'd0);

endmodule

// File: rtl/hstx_lane_ctrl.sv
// HS transmit lane controller: walks the LP-11 -> LP-01 -> LP-00 -> HS
// entry sequence, passes PPI payload bytes to the HS-TX core, emits the
// trail and returns to LP-11.
// Optional feature macro: HSTX_TIMING_PROG_EN adds cfg_t_* ports that
// replace the timing parameters, captured at the start of each burst.
//
// Handshake: in HS_DATA a byte moves on every cycle where hstx_ready and
// TxRequestHS are both 1; TxReadyHS and hstx_valid are high in exactly
// those cycles and hstx_byte carries TxDataHS combinationally.
module hstx_lane_ctrl
  import dphy_hstx_pkg::*;
#(
  parameter logic [7:0] T_LPX        = DEF_T_LPX,
  parameter logic [7:0] T_HS_PREPARE = DEF_T_HS_PREPARE,
  parameter logic [7:0] T_HS_ZERO    = DEF_T_HS_ZERO,
  parameter logic [7:0] T_HS_TRAIL   = DEF_T_HS_TRAIL,
  parameter logic [7:0] T_HS_EXIT    = DEF_T_HS_EXIT
) (
  input  logic       TxByteClkHS,
  input  logic       TxRst,
  input  logic       TxRequestHS,
  input  logic [7:0] TxDataHS,
  output logic       TxReadyHS,
  input  logic       hstx_ready,
  output logic       hstx_sot,
  output logic       hstx_valid,
  output logic [7:0] hstx_byte,
  output logic       hs_en,
  output logic       lp_dp,
  output logic       lp_dn,
  output logic [3:0] ctrl_state
`ifdef HSTX_TIMING_PROG_EN
  ,
  input  logic [7:0] cfg_t_lpx,
  input  logic [7:0] cfg_t_hs_prepare,
  input  logic [7:0] cfg_t_hs_zero,
  input  logic [7:0] cfg_t_hs_trail,
  input  logic [7:0] cfg_t_hs_exit
`endif
);

  ctrl_state_t state, state_nxt;
  logic        tmr_load;
  logic [7:0]  tmr_value;
  logic        tmr_done;
  logic        xfer;
  logic        last_bit7;
  logic        in_sync_d;

  // Timing values used by the next-state logic. t_lpx_entry is the value
  // loaded on the LP_IDLE -> LP_RQST edge, where captured registers are
  // not yet valid.
  logic [7:0] t_lpx_entry, t_lpx, t_prep, t_zero, t_trail, t_exit;

`ifdef HSTX_TIMING_PROG_EN
  logic [7:0] t_lpx_q, t_prep_q, t_zero_q, t_trail_q, t_exit_q;

  // Capture programmed timings as a burst starts; held until the next one.
  always_ff @(posedge TxByteClkHS) begin
    if (!TxRst) begin
      t_lpx_q   <= T_LPX;
      t_prep_q  <= T_HS_PREPARE;
      t_zero_q  <= T_HS_ZERO;
      t_trail_q <= T_HS_TRAIL;
      t_exit_q  <= T_HS_EXIT;
    end else if (state == LP_IDLE && TxRequestHS) begin
      t_lpx_q   <= cfg_t_lpx;
      t_prep_q  <= cfg_t_hs_prepare;
      t_zero_q  <= cfg_t_hs_zero;
      t_trail_q <= cfg_t_hs_trail;
      t_exit_q  <= cfg_t_hs_exit;
    end
  end

  assign t_lpx_entry = cfg_t_lpx;
  assign t_lpx       = t_lpx_q;
  assign t_prep      = t_prep_q;
  assign t_zero      = t_zero_q;
  assign t_trail     = t_trail_q;
  assign t_exit      = t_exit_q;
`else
  assign t_lpx_entry = T_LPX;
  assign t_lpx       = T_LPX;
  assign t_prep      = T_HS_PREPARE;
  assign t_zero      = T_HS_ZERO;
  assign t_trail     = T_HS_TRAIL;
  assign t_exit      = T_HS_EXIT;
`endif

  hstx_ctrl_timer u_timer (
    .clk   (TxByteClkHS),
    .rst_n (TxRst),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // State register; reset drops straight to LP_IDLE from any state.
  always_ff @(posedge TxByteClkHS) begin
    if (!TxRst) begin
      state <= LP_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, plus timer load on entry to each timed state.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_value = 8'd0;
    case (state)
      LP_IDLE: if (TxRequestHS) begin
        state_nxt = LP_RQST;
        tmr_load  = 1'b1;
        tmr_value = timer_load_val(t_lpx_entry);
      end
      LP_RQST: if (tmr_done) begin
        state_nxt = LP_BRIDGE;
        tmr_load  = 1'b1;
        tmr_value = timer_load_val(t_lpx);
      end
      LP_BRIDGE: if (tmr_done) begin
        state_nxt = HS_PREP;
        tmr_load  = 1'b1;
        tmr_value = timer_load_val(t_prep);
      end
      HS_PREP: if (tmr_done) begin
        state_nxt = HS_ZERO;
        tmr_load  = 1'b1;
        tmr_value = timer_load_val(t_zero);
      end
      HS_ZERO:  if (tmr_done)    state_nxt = HS_SYNC;
      HS_SYNC:  if (hstx_ready)  state_nxt = HS_DATA;
      HS_DATA: if (!TxRequestHS) begin
        state_nxt = HS_TRAIL;
        tmr_load  = 1'b1;
        tmr_value = timer_load_val(t_trail);
      end
      HS_TRAIL: if (tmr_done) begin
        state_nxt = HS_EXIT;
        tmr_load  = 1'b1;
        tmr_value = timer_load_val(t_exit);
      end
      HS_EXIT:  if (tmr_done)    state_nxt = LP_IDLE;
      default:  state_nxt = LP_IDLE;
    endcase
  end

  assign xfer = (state == HS_DATA) && hstx_ready && TxRequestHS;

  // Remember bit 7 of the last byte sent; selects the trail polarity.
  always_ff @(posedge TxByteClkHS) begin
    if (!TxRst) begin
      last_bit7 <= 1'b0;
    end else if (xfer) begin
      last_bit7 <= TxDataHS[7];
    end
  end

  // Delayed HS_SYNC flag so hstx_sot covers only the first HS_SYNC cycle.
  always_ff @(posedge TxByteClkHS) begin
    if (!TxRst) begin
      in_sync_d <= 1'b0;
    end else begin
      in_sync_d <= (state == HS_SYNC);
    end
  end

  assign hstx_sot   = (state == HS_SYNC) && !in_sync_d;
  assign ctrl_state = state;

  // Line levels and HS-TX core outputs decoded from the current state.
  always_comb begin
    lp_dp      = 1'b1;
    lp_dn      = 1'b1;
    hs_en      = 1'b0;
    TxReadyHS  = 1'b0;
    hstx_valid = 1'b0;
    hstx_byte  = 8'h00;
    case (state)
      LP_RQST: begin
        lp_dp = 1'b0;
      end
      LP_BRIDGE: begin
        lp_dp = 1'b0;
        lp_dn = 1'b0;
      end
      HS_PREP, HS_ZERO, HS_SYNC: begin
        lp_dp = 1'b0;
        lp_dn = 1'b0;
        hs_en = 1'b1;
      end
      HS_DATA: begin
        lp_dp      = 1'b0;
        lp_dn      = 1'b0;
        hs_en      = 1'b1;
        TxReadyHS  = xfer;
        hstx_valid = xfer;
        hstx_byte  = xfer ? TxDataHS : 8'h00;
      end
      HS_TRAIL: begin
        lp_dp      = 1'b0;
        lp_dn      = 1'b0;
        hs_en      = 1'b1;
        hstx_valid = 1'b1;
        hstx_byte  = last_bit7 ? 8'h00 : 8'hFF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hstx_lane_ctrl.sv
// Directed bench for hstx_lane_ctrl with default timing parameters.
// Cycle numbering: cycle 0 is the LP_IDLE cycle in which TxRequestHS is
// first seen high; expected states per cycle are written out by hand.
module tb_hstx_lane_ctrl;

  logic       clk;
  logic       TxRst;
  logic       TxRequestHS;
  logic [7:0] TxDataHS;
  logic       TxReadyHS;
  logic       hstx_ready;
  logic       hstx_sot;
  logic       hstx_valid;
  logic [7:0] hstx_byte;
  logic       hs_en;
  logic       lp_dp;
  logic       lp_dn;
  logic [3:0] ctrl_state;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  logic [7:0] exp_q[$];

  hstx_lane_ctrl dut (
    .TxByteClkHS (clk),
    .TxRst       (TxRst),
    .TxRequestHS (TxRequestHS),
    .TxDataHS    (TxDataHS),
    .TxReadyHS   (TxReadyHS),
    .hstx_ready  (hstx_ready),
    .hstx_sot    (hstx_sot),
    .hstx_valid  (hstx_valid),
    .hstx_byte   (hstx_byte),
    .hs_en       (hs_en),
    .lp_dp       (lp_dp),
    .lp_dn       (lp_dn),
    .ctrl_state  (ctrl_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  // Driver tasks: advance to just after a rising edge, then settle inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Hand table of the entry sequence with default timings.
  function automatic logic [3:0] pre_state(input int c);
    if (c <= 4)  return 4'd1;
    if (c <= 8)  return 4'd2;
    if (c <= 11) return 4'd3;
    return 4'd4;
  endfunction

  task automatic run_preamble(input int first_c, input int drop_c);
    for (int c = first_c; c <= 21; c++) begin
      tick();
      if (c == drop_c) TxRequestHS = 1'b0;
      settle();
      chk("pre_state", ctrl_state, pre_state(c));
      chk("pre_lp_dp", lp_dp, 1'b0);
      chk("pre_lp_dn", lp_dn, (c <= 4) ? 1'b1 : 1'b0);
      chk("pre_hs_en", hs_en, (c >= 9) ? 1'b1 : 1'b0);
      chk("pre_valid", hstx_valid, 1'b0);
    end
  endtask

  // Scoreboard side: one data cycle; an accepted byte is checked in order.
  task automatic data_cycle(input logic [7:0] d, input logic rdy);
    tick();
    TxDataHS   = d;
    hstx_ready = rdy;
    if (rdy) exp_q.push_back(d);
    settle();
    chk("data_state", ctrl_state, 4'd6);
    chk("data_ready", TxReadyHS, rdy);
    chk("data_valid", hstx_valid, rdy);
    if (TxReadyHS === 1'b1) begin
      n_acc++;
      if (exp_q.size() > 0) chk("data_byte", hstx_byte, exp_q.pop_front());
      else chk("data_unexpected", hstx_byte, 8'hxx);
    end
  endtask

  task automatic trail_exit(input logic [7:0] trail_b, input logic req_during);
    for (int k = 0; k < 4; k++) begin
      tick();
      TxRequestHS = req_during;
      settle();
      chk("trail_state", ctrl_state, 4'd7);
      chk("trail_valid", hstx_valid, 1'b1);
      chk("trail_byte", hstx_byte, trail_b);
      chk("trail_hs_en", hs_en, 1'b1);
      chk("trail_txready", TxReadyHS, 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      settle();
      chk("exit_state", ctrl_state, 4'd8);
      chk("exit_lp_dp", lp_dp, 1'b1);
      chk("exit_lp_dn", lp_dn, 1'b1);
      chk("exit_hs_en", hs_en, 1'b0);
      chk("exit_valid", hstx_valid, 1'b0);
    end
  endtask

  logic [7:0] burst_a [3] = '{8'hA5, 8'h3C, 8'h81};
  logic [7:0] burst_b [3] = '{8'h12, 8'h34, 8'h7E};

  initial begin
    TxRst       = 1'b0;
    TxRequestHS = 1'b0;
    TxDataHS    = 8'h00;
    hstx_ready  = 1'b0;

    // Reset state
    repeat (3) tick();
    settle();
    chk("rst_state", ctrl_state, 4'd0);
    chk("rst_lp_dp", lp_dp, 1'b1);
    chk("rst_lp_dn", lp_dn, 1'b1);
    chk("rst_hs_en", hs_en, 1'b0);
    chk("rst_sot", hstx_sot, 1'b0);
    chk("rst_valid", hstx_valid, 1'b0);
    chk("rst_byte", hstx_byte, 8'h00);
    chk("rst_txready", TxReadyHS, 1'b0);
    TxRst = 1'b1;
    tick();

    // Burst A: entry timing, three bytes, trail 00 (last byte bit 7 = 1)
    TxRequestHS = 1'b1;
    settle();
    chk("a_c0_state", ctrl_state, 4'd0);
    run_preamble(1, 0);
    tick();
    hstx_ready = 1'b1;
    settle();
    chk("a_sync_state", ctrl_state, 4'd5);
    chk("a_sot", hstx_sot, 1'b1);
    chk("a_sync_valid", hstx_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      data_cycle(burst_a[i], 1'b1);
      chk("a_sot_low", hstx_sot, 1'b0);
    end
    tick();
    TxRequestHS = 1'b0;
    TxDataHS    = 8'h55;
    settle();
    chk("a_drop_state", ctrl_state, 4'd6);
    chk("a_drop_txready", TxReadyHS, 1'b0);
    chk("a_drop_valid", hstx_valid, 1'b0);
    trail_exit(8'h00, 1'b0);
    tick();
    settle();
    chk("a_idle_state", ctrl_state, 4'd0);
    chk("a_accepted", 8'(n_acc), 8'd3);

    // Burst B: HS_SYNC waits on ready, toggled ready, trail FF,
    // request held high through trail/exit is ignored until LP_IDLE
    n_acc = 0;
    hstx_ready = 1'b0;
    TxRequestHS = 1'b1;
    settle();
    chk("b_c0_state", ctrl_state, 4'd0);
    run_preamble(1, 0);
    tick();
    settle();
    chk("b_sync_state", ctrl_state, 4'd5);
    chk("b_sot", hstx_sot, 1'b1);
    tick();
    settle();
    chk("b_sync_wait", ctrl_state, 4'd5);
    chk("b_sot_once", hstx_sot, 1'b0);
    tick();
    hstx_ready = 1'b1;
    settle();
    chk("b_sync_wait2", ctrl_state, 4'd5);
    chk("b_sot_once2", hstx_sot, 1'b0);
    for (int i = 0; i < 3; i++) begin
      data_cycle(burst_b[i], 1'b0);
      data_cycle(burst_b[i], 1'b1);
    end
    tick();
    TxRequestHS = 1'b0;
    settle();
    chk("b_drop_state", ctrl_state, 4'd6);
    chk("b_drop_txready", TxReadyHS, 1'b0);
    trail_exit(8'hFF, 1'b1);
    tick();
    settle();
    chk("b_idle_state", ctrl_state, 4'd0);
    chk("b_accepted", 8'(n_acc), 8'd3);
    tick();
    settle();
    chk("b_restart_state", ctrl_state, 4'd1);

    // Reset mid-burst in HS_DATA
    run_preamble(2, 0);
    tick();
    settle();
    chk("r_sync_state", ctrl_state, 4'd5);
    data_cycle(8'h81, 1'b1);
    tick();
    TxRst    = 1'b0;
    TxDataHS = 8'h22;
    settle();
    chk("r_pre_state", ctrl_state, 4'd6);
    tick();
    settle();
    chk("r_state", ctrl_state, 4'd0);
    chk("r_lp_dp", lp_dp, 1'b1);
    chk("r_lp_dn", lp_dn, 1'b1);
    chk("r_hs_en", hs_en, 1'b0);
    chk("r_valid", hstx_valid, 1'b0);
    chk("r_txready", TxReadyHS, 1'b0);
    TxRequestHS = 1'b0;
    hstx_ready  = 1'b0;
    tick();
    TxRst = 1'b1;
    tick();

    // Request dropped in HS_ZERO: empty HS_DATA cycle, trail FF
    TxRequestHS = 1'b1;
    settle();
    chk("c_c0_state", ctrl_state, 4'd0);
    run_preamble(1, 12);
    tick();
    hstx_ready = 1'b1;
    settle();
    chk("c_sync_state", ctrl_state, 4'd5);
    chk("c_sot", hstx_sot, 1'b1);
    tick();
    settle();
    chk("c_data_state", ctrl_state, 4'd6);
    chk("c_data_txready", TxReadyHS, 1'b0);
    chk("c_data_valid", hstx_valid, 1'b0);
    trail_exit(8'hFF, 1'b0);
    tick();
    settle();
    chk("c_idle_state", ctrl_state, 4'd0);
    chk("sb_empty", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
